// File: rtl/led_panel_receiver.sv
// LED panel shift-interface receiver: syncs driver outputs, rebuilds rows,
// commits them to an R/G/B framebuffer with a registered row read port.
module led_panel_receiver #(
  parameter int COLS = 32,
  parameter int ROWS = 16,
  localparam int ROW_BITS = $clog2(ROWS),
  localparam int ADDRESS_BITS = $clog2(ROWS / 2)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_lp_clock,
  input  logic                    i_lp_latch,
  input  logic                    i_lp_blank,
  input  logic [2:0]              i_lp_rgb_0,
  input  logic [2:0]              i_lp_rgb_1,
  input  logic [4:0]              i_lp_address,
  input  logic [ROW_BITS-1:0]     i_read_row,
  output logic [COLS-1:0]         o_read_r,
  output logic [COLS-1:0]         o_read_g,
  output logic [COLS-1:0]         o_read_b,
  output logic                    o_row_valid,
  output logic [ADDRESS_BITS-1:0] o_row_address,
  output logic [15:0]             o_frame_count,
  output logic                    o_error,
  output logic                    o_blank
);

  localparam int SW = 9 + ADDRESS_BITS;
  localparam int CNT_BITS = $clog2(COLS + 2);
  localparam logic [SW-1:0] SYNC_RST =
    {2'b00, 1'b1, {(6 + ADDRESS_BITS){1'b0}}};

  logic [SW-1:0] w_in;
  logic [SW-1:0] r_s1;
  logic [SW-1:0] r_s2;
  logic          r_s3_clk;
  logic          r_s3_latch;

  logic                    w_clk;
  logic                    w_latch;
  logic                    w_blank;
  logic [2:0]              w_rgb0;
  logic [2:0]              w_rgb1;
  logic [ADDRESS_BITS-1:0] w_addr;
  logic                    w_shift;
  logic                    w_commit;
  logic [ROW_BITS-1:0]     w_row_hi;
  logic [ROW_BITS-1:0]     w_row_lo;
  logic                    w_unused_addr;

  logic [2:0][COLS-1:0] r_sr0;
  logic [2:0][COLS-1:0] r_sr1;
  logic [CNT_BITS-1:0]  r_count;
  logic [COLS-1:0]      r_fb_r [ROWS];
  logic [COLS-1:0]      r_fb_g [ROWS];
  logic [COLS-1:0]      r_fb_b [ROWS];

  assign w_in = {i_lp_clock, i_lp_latch, i_lp_blank, i_lp_rgb_0,
                 i_lp_rgb_1, i_lp_address[ADDRESS_BITS-1:0]};
  assign w_unused_addr = ^i_lp_address[4:ADDRESS_BITS];

  assign w_clk   = r_s2[SW-1];
  assign w_latch = r_s2[SW-2];
  assign w_blank = r_s2[SW-3];
  assign w_rgb0  = r_s2[SW-4 -: 3];
  assign w_rgb1  = r_s2[SW-7 -: 3];
  assign w_addr  = r_s2[ADDRESS_BITS-1:0];

  assign w_shift  = w_clk & ~r_s3_clk & ~w_latch;
  assign w_commit = ~w_latch & r_s3_latch;
  assign w_row_hi = ROW_BITS'(w_addr);
  assign w_row_lo = w_row_hi + ROW_BITS'(ROWS / 2);

  // All panel inputs share one synchronizer so data stays aligned to edges
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_s1       <= SYNC_RST;
      r_s2       <= SYNC_RST;
      r_s3_clk   <= 1'b0;
      r_s3_latch <= 1'b0;
      o_blank    <= 1'b1;
    end else begin
      r_s1       <= w_in;
      r_s2       <= r_s1;
      r_s3_clk   <= w_clk;
      r_s3_latch <= w_latch;
      o_blank    <= w_blank;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sr0         <= '0;
      r_sr1         <= '0;
      r_count       <= '0;
      o_row_valid   <= 1'b0;
      o_row_address <= '0;
      o_frame_count <= '0;
      o_error       <= 1'b0;
    end else begin
      o_row_valid <= 1'b0;
      if (w_shift) begin
        for (int c = 0; c < 3; c++) begin
          r_sr0[c] <= {r_sr0[c][COLS-2:0], w_rgb0[c]};
          r_sr1[c] <= {r_sr1[c][COLS-2:0], w_rgb1[c]};
        end
        if (r_count != CNT_BITS'(COLS + 1))
          r_count <= r_count + 1'b1;
      end
      if (w_commit) begin
        r_count <= '0;
        if (r_count == CNT_BITS'(COLS)) begin
          o_row_valid   <= 1'b1;
          o_row_address <= w_addr;
          if (w_addr == ADDRESS_BITS'(ROWS / 2 - 1))
            o_frame_count <= o_frame_count + 16'd1;
        end else begin
          o_error <= 1'b1;
        end
      end
    end
  end

  // Read samples the array before this cycle's write lands
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < ROWS; i++) begin
        r_fb_r[i] <= '0;
        r_fb_g[i] <= '0;
        r_fb_b[i] <= '0;
      end
      o_read_r <= '0;
      o_read_g <= '0;
      o_read_b <= '0;
    end else begin
      o_read_r <= r_fb_r[i_read_row];
      o_read_g <= r_fb_g[i_read_row];
      o_read_b <= r_fb_b[i_read_row];
      if (w_commit && r_count == CNT_BITS'(COLS)) begin
        r_fb_r[w_row_hi] <= r_sr0[0];
        r_fb_g[w_row_hi] <= r_sr0[1];
        r_fb_b[w_row_hi] <= r_sr0[2];
        r_fb_r[w_row_lo] <= r_sr1[0];
        r_fb_g[w_row_lo] <= r_sr1[1];
        r_fb_b[w_row_lo] <= r_sr1[2];
      end
    end
  end

endmodule

// File: tb/tb_led_panel_receiver.sv
// Directed bench for led_panel_receiver: reset, rows, frames,
// malformed rows, read/write collision and mid-row reset.
module tb_led_panel_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lp_clock = 1'b0;
  logic        lp_latch = 1'b0;
  logic        lp_blank = 1'b1;
  logic [2:0]  lp_rgb_0 = '0;
  logic [2:0]  lp_rgb_1 = '0;
  logic [4:0]  lp_address = '0;
  logic [3:0]  read_row = '0;
  logic [31:0] read_r;
  logic [31:0] read_g;
  logic [31:0] read_b;
  logic        row_valid;
  logic [2:0]  row_address;
  logic [15:0] frame_count;
  logic        error;
  logic        blank;

  int total = 0;
  int bad = 0;
  int vcnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (row_valid) vcnt++;

  led_panel_receiver dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_lp_clock(lp_clock),
    .i_lp_latch(lp_latch),
    .i_lp_blank(lp_blank),
    .i_lp_rgb_0(lp_rgb_0),
    .i_lp_rgb_1(lp_rgb_1),
    .i_lp_address(lp_address),
    .i_read_row(read_row),
    .o_read_r(read_r),
    .o_read_g(read_g),
    .o_read_b(read_b),
    .o_row_valid(row_valid),
    .o_row_address(row_address),
    .o_frame_count(frame_count),
    .o_error(error),
    .o_blank(blank)
  );

  function automatic logic [31:0] pat(int row, int pass, int col);
    logic [31:0] v;
    v = 32'h01010101 * 32'(row + 1);
    v = v ^ (32'h000000FF << (col * 8));
    if (pass != 0) v = v ^ 32'hA5A50000;
    return v;
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic shift_bit(logic [2:0] c0, logic [2:0] c1);
    lp_rgb_0 = c0;
    lp_rgb_1 = c1;
    lp_clock = 1'b1;
    step(1);
    lp_clock = 1'b0;
    step(1);
  endtask

  task automatic shift_word(int n,
                            logic [31:0] r0, logic [31:0] g0,
                            logic [31:0] b0, logic [31:0] r1,
                            logic [31:0] g1, logic [31:0] b1);
    for (int i = n - 1; i >= 0; i--)
      shift_bit({b0[i], g0[i], r0[i]}, {b1[i], g1[i], r1[i]});
  endtask

  task automatic pulse_latch(logic [4:0] a);
    lp_address = a;
    lp_latch = 1'b1;
    step(1);
    lp_latch = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (row_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_row(logic [4:0] a,
                          logic [31:0] r0, logic [31:0] g0,
                          logic [31:0] b0, logic [31:0] r1,
                          logic [31:0] g1, logic [31:0] b1,
                          output bit got);
    shift_word(32, r0, g0, b0, r1, g1, b1);
    pulse_latch(a);
    wait_valid(got);
  endtask

  task automatic rd(int row);
    read_row = 4'(row);
    step(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    total++;
    if (read_r !== 32'h0 || read_g !== 32'h0 || read_b !== 32'h0) begin
      bad++;
      $display("FAIL reset_read got=%h/%h/%h exp=0", read_r, read_g, read_b);
    end
    total++;
    if (blank !== 1'b1 || error !== 1'b0 || row_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got blank=%b err=%b valid=%b exp 1/0/0",
               blank, error, row_valid);
    end
    total++;
    if (frame_count !== 16'd0 || row_address !== 3'd0) begin
      bad++;
      $display("FAIL reset_counts got fc=%0d addr=%0d exp 0/0",
               frame_count, row_address);
    end
    rst = 1'b0;
    lp_blank = 1'b0;
    step(3);
    total++;
    if (blank !== 1'b0) begin
      bad++;
      $display("FAIL blank_follow got=%b exp=0", blank);
    end
  endtask

  task automatic test_single_row();
    bit got;
    int v0;
    v0 = vcnt;
    send_row(5'd3, 32'h80000000, 32'h0, 32'h0,
             32'h0, 32'hFFFFFFFF, 32'h0, got);
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL single_valid got=%b exp=1", got);
    end
    step(1);
    total++;
    if (row_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pulse_width got=%b exp=0", row_valid);
    end
    step(4);
    total++;
    if (vcnt - v0 !== 1 || row_address !== 3'd3) begin
      bad++;
      $display("FAIL single_count got pulses=%0d addr=%0d exp 1/3",
               vcnt - v0, row_address);
    end
    rd(3);
    total++;
    if (read_r !== 32'h80000000 || read_g !== 32'h0 || read_b !== 32'h0) begin
      bad++;
      $display("FAIL single_row3 got=%h/%h/%h exp=80000000/0/0",
               read_r, read_g, read_b);
    end
    rd(11);
    total++;
    if (read_r !== 32'h0 || read_g !== 32'hFFFFFFFF || read_b !== 32'h0) begin
      bad++;
      $display("FAIL single_row11 got=%h/%h/%h exp=0/ffffffff/0",
               read_r, read_g, read_b);
    end
    total++;
    if (frame_count !== 16'd0) begin
      bad++;
      $display("FAIL single_frames got=%0d exp=0", frame_count);
    end
  endtask

  task automatic test_full_frame();
    bit got;
    int hits;
    hits = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 8; a++) begin
        send_row(5'(a), pat(a, p, 0), pat(a, p, 1), pat(a, p, 2),
                 pat(a + 8, p, 0), pat(a + 8, p, 1), pat(a + 8, p, 2),
                 got);
        if (got) hits++;
      end
    end
    step(2);
    total++;
    if (hits !== 16) begin
      bad++;
      $display("FAIL frame_commits got=%0d exp=16", hits);
    end
    total++;
    if (frame_count !== 16'd2) begin
      bad++;
      $display("FAIL frame_count got=%0d exp=2", frame_count);
    end
    for (int r = 0; r < 16; r++) begin
      rd(r);
      total++;
      if (read_r !== pat(r, 1, 0) || read_g !== pat(r, 1, 1) ||
          read_b !== pat(r, 1, 2)) begin
        bad++;
        $display("FAIL frame_row%0d got=%h/%h/%h exp=%h/%h/%h", r,
                 read_r, read_g, read_b,
                 pat(r, 1, 0), pat(r, 1, 1), pat(r, 1, 2));
      end
    end
  endtask

  task automatic test_short_row();
    bit got;
    shift_word(31, '1, '1, '1, '1, '1, '1);
    pulse_latch(5'd5);
    wait_valid(got);
    total++;
    if (got !== 1'b0 || error !== 1'b1) begin
      bad++;
      $display("FAIL short_reject got valid=%b err=%b exp 0/1", got, error);
    end
    rd(5);
    total++;
    if (read_r !== pat(5, 1, 0) || read_b !== pat(5, 1, 2)) begin
      bad++;
      $display("FAIL short_unchanged got=%h/%h exp=%h/%h",
               read_r, read_b, pat(5, 1, 0), pat(5, 1, 2));
    end
    send_row(5'd5, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F,
             32'h1, 32'h2, 32'h3, got);
    total++;
    if (got !== 1'b1 || error !== 1'b1) begin
      bad++;
      $display("FAIL short_recover got valid=%b err=%b exp 1/1", got, error);
    end
    rd(5);
    total++;
    if (read_r !== 32'h12345678 || read_g !== 32'h9ABCDEF0 ||
        read_b !== 32'h0F0F0F0F) begin
      bad++;
      $display("FAIL short_next_row got=%h/%h/%h exp=12345678/9abcdef0/0f0f0f0f",
               read_r, read_g, read_b);
    end
    rd(13);
    total++;
    if (read_r !== 32'h1 || read_g !== 32'h2 || read_b !== 32'h3) begin
      bad++;
      $display("FAIL short_next_row13 got=%h/%h/%h exp=1/2/3",
               read_r, read_g, read_b);
    end
  endtask

  task automatic test_collision();
    bit got;
    rd(2);
    total++;
    if (read_r !== pat(2, 1, 0)) begin
      bad++;
      $display("FAIL coll_before got=%h exp=%h", read_r, pat(2, 1, 0));
    end
    shift_word(32, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    pulse_latch(5'd2);
    wait_valid(got);
    total++;
    if (got !== 1'b1 || read_r !== pat(2, 1, 0)) begin
      bad++;
      $display("FAIL coll_same_cycle got valid=%b data=%h exp 1/%h",
               got, read_r, pat(2, 1, 0));
    end
    step(1);
    total++;
    if (read_r !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL coll_next_cycle got=%h exp=cafef00d", read_r);
    end
  endtask

  task automatic test_reset_midrow();
    bit got;
    shift_word(10, '1, '1, '1, '1, '1, '1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    total++;
    if (error !== 1'b0 || frame_count !== 16'd0) begin
      bad++;
      $display("FAIL midrst_flags got err=%b fc=%0d exp 0/0",
               error, frame_count);
    end
    rd(5);
    total++;
    if (read_r !== 32'h0) begin
      bad++;
      $display("FAIL midrst_cleared got=%h exp=0", read_r);
    end
    send_row(5'd4, 32'hDEADBEEF, 32'h00FF00FF, 32'h55AA55AA,
             32'h11111111, 32'h22222222, 32'h33333333, got);
    step(1);
    total++;
    if (got !== 1'b1 || error !== 1'b0 || row_address !== 3'd4) begin
      bad++;
      $display("FAIL midrst_commit got valid=%b err=%b addr=%0d exp 1/0/4",
               got, error, row_address);
    end
    rd(4);
    total++;
    if (read_r !== 32'hDEADBEEF || read_g !== 32'h00FF00FF ||
        read_b !== 32'h55AA55AA) begin
      bad++;
      $display("FAIL midrst_row4 got=%h/%h/%h exp=deadbeef/00ff00ff/55aa55aa",
               read_r, read_g, read_b);
    end
    rd(12);
    total++;
    if (read_r !== 32'h11111111 || read_b !== 32'h33333333) begin
      bad++;
      $display("FAIL midrst_row12 got=%h/%h exp=11111111/33333333",
               read_r, read_b);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_full_frame();
    test_short_row();
    test_collision();
    test_reset_midrow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_panel_receiver.md
# led_panel_receiver

Panel-side receiver for the LED panel shift interface (serial clock, latch, blank, two RGB lanes, row address). Samples the driver's outputs in the system clock domain, reassembles shifted columns into rows, and commits them to an internal R/G/B framebuffer of ROWS×COLS bits, one bit per colour per pixel. Serves as the loopback/emulation partner of the panel driver in simulation and on-board self-test; a registered read port exposes any row for checking.

## Interface

- COLS, 32, columns per row; bits shifted per latch.
- ROWS, 16, total panel rows; address space is ROWS/2 (upper half on lane 1).
- Derived: COL_BITS = bits_for(COLS-1), ROW_BITS = bits_for(ROWS-1), ADDRESS_BITS = bits_for(ROWS/2-1).

- i_clock  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_lp_clock  in  1  panel shift clock from driver.
- i_lp_latch  in  1  panel latch.
- i_lp_blank  in  1  panel blank.
- i_lp_rgb_0  in  3  {b,g,r} for upper-half row.
- i_lp_rgb_1  in  3  {b,g,r} for lower-half row.
- i_lp_address  in  5  row address; only [ADDRESS_BITS-1:0] used.
- i_read_row  in  ROW_BITS  framebuffer row to read.
- o_read_r, o_read_g, o_read_b  out  COLS  row contents, bit n = column n.
- o_row_valid  out  1  one-cycle pulse per committed row.
- o_row_address  out  ADDRESS_BITS  address of last committed row.
- o_frame_count  out  16  completed frames, wraps at 65535→0.
- o_error  out  1  sticky malformed-row flag.
- o_blank  out  1  synchronized blank state.

## Operation

- All i_lp_* inputs pass through the same two-flop synchronizer, keeping data aligned to clock/latch. A third register on synchronized clock and latch provides edge detection.
- Shift: on each detected rising edge of synchronized clock while synchronized latch is low, shift r/g/b of both lanes into six COLS-bit registers as {sr[COLS-2:0], bit}; the first bit shifted ends up in column COLS-1. Bit counter increments, saturating at COLS+1. Clock edges while latch is high are ignored.
- Commit: on detected falling edge of synchronized latch, using synchronized address A sampled that cycle (driver updates address in the same cycle latch drops):
  - if count == COLS: write lane 0 registers to row A, lane 1 to row A+ROWS/2; pulse o_row_valid; o_row_address <= A; if A == ROWS/2-1, o_frame_count increments.
  - else: no write, no pulse, o_error <= 1.
  - count <= 0 in both cases.
- Latch rising edge: no action.
- Read port: o_read_* <= framebuffer[i_read_row] every cycle. Commit to the row being read in the same cycle: read returns old data; new data appears the next cycle.
- o_blank = synchronized blank (informational; does not gate commits).
- Reset: framebuffer, shift registers, counter, o_read_* = 0; o_row_valid 0; o_row_address 0; o_frame_count 0; o_error 0; o_blank 1; synchronizer flops cleared except blank path (1). Reset mid-row discards partial row; the first latch fall after reset with count != COLS sets o_error.

## Timing

- Input sampled first at i_clock edge k → action registered at edge k+2 (2-cycle latency for shift, commit, o_row_valid, o_blank).
- Framebuffer write at edge k+2; o_read_* reflects it at edge k+3.
- Minimum input high/low phase: 1 i_clock cycle (driver runs on the same clock; no edges lost).
- o_row_valid high exactly one cycle; back-to-back commits need ≥2 cycles between latch falls (guaranteed by protocol).

## Test plan

- Reset: hold i_reset 2 cycles → all o_read_* 0, o_blank 1, o_error 0, o_frame_count 0.
- Single row: shift 32 bits with r0 = 1 only on first bit, g1 = 1 on all bits, latch pulse, address 3 → o_row_valid once, o_row_address 3, row 3 r = 0x80000000, row 11 g = 0xFFFFFFFF.
- Full frame: addresses 0..7 with row-index pattern, twice → o_frame_count 2, all 16 rows read back matching.
- Short row: 31 clocks then latch → no o_row_valid, o_error 1, target row unchanged; next good row commits, o_error stays 1.
- Read/write collision: i_read_row = 2 while row 2 commits → old data that cycle, new data next cycle.
- Reset after 10 bits shifted, then 32 bits + latch → commit correct, no carryover of the partial row.
